piece_mover: RTL and testbench
==============================

Name: piece_mover

Overview:
- Active-piece stage directly upstream of the clear/redraw stage, operating during the MOVE phase (state == 1).
- On entry to MOVE it takes the freshly spawned board, separates the settled cells from the spawned piece, and tracks the piece's row and column.
- It applies left/right requests and gravity ticks with collision checks, and drives the merged board (settled | piece) back to the clear/redraw stage every cycle.
- It pulses `landed` when the piece can no longer fall, which ends the MOVE phase.

Parameters:
- MOVE_STATE, 3'd1, game-phase code during which the block is active.
- SPAWN_COL, 1, anchor column at spawn (anchor row is always 0).

Ports:
- clka  in  1  single clock; all logic on posedge.
- restart  in  1  synchronous reset, active-high.
- state  in  3  game phase from the top-level FSM.
- board_in  in  32  board from clear/redraw, with the spawned piece already drawn.
- curr_piece  in  2  shape code: 00 single, 01 horizontal pair, 10 2x2 square, 11 L.
- btn_left  in  1  move-left request, level-sampled each cycle.
- btn_right  in  1  move-right request, level-sampled each cycle.
- drop_tick  in  1  gravity strobe, one-cycle pulse.
- board_out  out  32  settled | active-piece mask.
- landed  out  1  one-cycle pulse when the piece locks.
- piece_row  out  3  anchor row.
- piece_col  out  2  anchor column.

Behaviour:
- Board encoding:
  - 8 rows x 4 cols; cell(r,c) = bit r*4+c.
  - Row 0 (bits 3:0) is the top; row 7 (bits 31:28) is the bottom.
- Shape masks relative to anchor (r,c), with width w and height h:
  - 00: (0,0); w=1, h=1.
  - 01: (0,0),(0,1); w=2, h=1.
  - 10: (0,0),(0,1),(1,0),(1,1); w=2, h=2.
  - 11: (0,0),(1,0),(1,1); w=2, h=2.
- Reset (restart=1 at posedge), overriding everything:
  - board_out=0, landed=0, piece_row=0, piece_col=0.
  - Internal settled register=0, shape=0, FSM=IDLE.
- FSM has three states: IDLE, ACTIVE, DONE.
- IDLE:
  - Outputs hold their values.
  - When state==MOVE_STATE: latch shape<=curr_piece; settled<=board_in & ~mask(curr_piece,0,SPAWN_COL); row<=0; col<=SPAWN_COL; board_out<=board_in. Go to ACTIVE.
- ACTIVE: at most one action per cycle, in priority order:
  1. drop_tick:
     - If row+h==8 or mask(row+1,col) & settled != 0, then landed<=1 for one cycle, board_out holds settled|mask(row,col), go to DONE.
     - Otherwise row<=row+1.
  2. btn_left & ~btn_right: col<=col-1 if col>0 and mask(row,col-1) & settled == 0; otherwise no change.
  3. btn_right & ~btn_left: col<=col+1 if col+w<4 and mask(row,col+1) & settled == 0; otherwise no change.
  4. Both buttons high: no move.
- board_out is registered and equals settled|mask(new row, new col) one cycle after the action is sampled. A blocked move leaves board_out unchanged.
- DONE:
  - board_out held, landed=0.
  - Return to IDLE when state!=MOVE_STATE.
- Abort: if state!=MOVE_STATE while ACTIVE, go to IDLE with no landed pulse and board_out held.
- landed is never high for two consecutive cycles.
- piece_row and piece_col always mirror the internal anchor.
- Arithmetic:
  - row is 3-bit and never exceeds 8-h.
  - col is 2-bit and never exceeds 4-w.
  - No wrap-around permitted.

Test Plan:
- Gravity: piece 00, board_in=32'h00000002, state=1, 7 drop_ticks -> board_out=32'h20000000, piece_row=7; 8th tick -> landed=1 for exactly one cycle, board_out stays 32'h20000000.
- Lateral bounds: piece 01, board_in=32'h00000006:
  - left -> board_out=32'h00000003, col=0; a second left -> unchanged.
  - Then 2 rights -> board_out=32'h0000000C, col=2; a third right -> unchanged.
- Collision landing: square, board_in=32'h60000066 (settled row-7 cells (7,1),(7,2)):
  - 5 drop_ticks -> board_out=32'h66600000, row=5.
  - 6th tick -> landed pulse, board_out=32'h66600000.
- Side collision: piece 00, board_in=32'h00000003 (settled cell (0,0)), btn_left -> no move, board_out=32'h00000003; simultaneous btn_left+btn_right -> no move.
- Priority: drop_tick and btn_right in the same cycle on piece 00 at spawn -> only the drop occurs, board_out=32'h00000020.
- Reset/abort:
  - restart mid-ACTIVE -> next cycle board_out=0, landed=0, FSM IDLE.
  - state changes 1->2 mid-ACTIVE -> no landed pulse; a fresh state=1 re-latches the spawn.

Source files
------------

// File: rtl/piece_mover.sv
// piece_mover
//   Active-piece stage for the MOVE phase. On entry to MOVE it splits the
//   freshly spawned board into settled cells and the spawned piece. It then
//   applies gravity ticks and left/right requests with collision checks, and
//   drives the merged board back to the clear/redraw stage.
//
// Ports
//   clka        in   1   clock, all logic on posedge
//   restart     in   1   synchronous reset, active-high
//   state       in   3   game phase from the top-level FSM
//   board_in    in  32   board with the spawned piece already drawn
//   curr_piece  in   2   shape code: 00 single, 01 pair, 10 square, 11 L
//   btn_left    in   1   move-left request (level)
//   btn_right   in   1   move-right request (level)
//   drop_tick   in   1   gravity strobe (one-cycle pulse)
//   board_out   out 32   settled | active-piece mask (registered)
//   landed      out  1   one-cycle pulse when the piece locks
//   piece_row   out  3   anchor row
//   piece_col   out  2   anchor column
//
// Board encoding: 8 rows x 4 cols, cell(r,c) = bit r*4+c, row 0 on top.

module piece_mover #(
    parameter logic [2:0] MOVE_STATE = 3'd1,
    parameter logic [1:0] SPAWN_COL  = 2'd1
) (
    input  logic        clka,
    input  logic        restart,
    input  logic [2:0]  state,
    input  logic [31:0] board_in,
    input  logic [1:0]  curr_piece,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        drop_tick,
    output logic [31:0] board_out,
    output logic        landed,
    output logic [2:0]  piece_row,
    output logic [1:0]  piece_col
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } fsm_t;

    fsm_t        fsm;
    logic [31:0] settled;
    logic [1:0]  shape;

    // Shape footprint placed at anchor (r,c). The anchor inputs are one bit
    // wider than the registers so "one row below the floor" is expressible;
    // any cell pushed past bit 31 simply shifts out of the board.
    function automatic logic [31:0] piece_mask(input logic [1:0] shp,
                                               input logic [3:0] r,
                                               input logic [2:0] c);
        logic [31:0] base;
        logic [5:0]  sh;
        case (shp)
            2'b00:   base = 32'h0000_0001;  // (0,0)
            2'b01:   base = 32'h0000_0003;  // (0,0),(0,1)
            2'b10:   base = 32'h0000_0033;  // (0,0),(0,1),(1,0),(1,1)
            default: base = 32'h0000_0031;  // (0,0),(1,0),(1,1)
        endcase
        sh = {r, 2'b00} + {3'b000, c};
        return base << sh;
    endfunction

    function automatic logic [2:0] shape_width(input logic [1:0] shp);
        return (shp == 2'b00) ? 3'd1 : 3'd2;
    endfunction

    function automatic logic [2:0] shape_height(input logic [1:0] shp);
        return shp[1] ? 3'd2 : 3'd1;
    endfunction

    logic [3:0]  row_ext;
    logic [2:0]  col_ext;
    logic [31:0] mask_here;
    logic [31:0] mask_down;
    logic [31:0] mask_left;
    logic [31:0] mask_right;
    logic [31:0] spawn_mask;
    logic        at_floor;
    logic        blocked_down;
    logic        can_left;
    logic        can_right;

    assign row_ext    = {1'b0, piece_row};
    assign col_ext    = {1'b0, piece_col};
    assign mask_here  = piece_mask(shape, row_ext, col_ext);
    assign mask_down  = piece_mask(shape, row_ext + 4'd1, col_ext);
    // At col 0 the left mask is garbage, but can_left gates it out first.
    assign mask_left  = piece_mask(shape, row_ext, col_ext - 3'd1);
    assign mask_right = piece_mask(shape, row_ext, col_ext + 3'd1);
    assign spawn_mask = piece_mask(curr_piece, 4'd0, {1'b0, SPAWN_COL});

    assign at_floor     = (row_ext + {1'b0, shape_height(shape)}) == 4'd8;
    assign blocked_down = at_floor || (|(mask_down & settled));
    assign can_left     = (piece_col != 2'd0) && !(|(mask_left & settled));
    assign can_right    = ((col_ext + shape_width(shape)) < 3'd4)
                          && !(|(mask_right & settled));

    // NOTE: all state here updates with non-blocking assignments so every
    // branch reads the pre-edge anchor/settled values, matching the
    // combinational masks computed above.
    always_ff @(posedge clka) begin
        if (restart) begin
            fsm       <= IDLE;
            settled   <= '0;
            shape     <= '0;
            board_out <= '0;
            landed    <= 1'b0;
            piece_row <= '0;
            piece_col <= '0;
        end else begin
            landed <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (state == MOVE_STATE) begin
                        shape     <= curr_piece;
                        settled   <= board_in & ~spawn_mask;
                        piece_row <= '0;
                        piece_col <= SPAWN_COL;
                        board_out <= board_in;
                        fsm       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (state != MOVE_STATE) begin
                        // Abort: leave quietly, board_out held.
                        fsm <= IDLE;
                    end else if (drop_tick) begin
                        if (blocked_down) begin
                            landed    <= 1'b1;
                            board_out <= settled | mask_here;
                            fsm       <= DONE;
                        end else begin
                            piece_row <= piece_row + 3'd1;
                            board_out <= settled | mask_down;
                        end
                    end else if (btn_left && !btn_right) begin
                        if (can_left) begin
                            piece_col <= piece_col - 2'd1;
                            board_out <= settled | mask_left;
                        end
                    end else if (btn_right && !btn_left) begin
                        if (can_right) begin
                            piece_col <= piece_col + 2'd1;
                            board_out <= settled | mask_right;
                        end
                    end
                end
                DONE: begin
                    if (state != MOVE_STATE) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_mover.sv
// Directed testbench for piece_mover. Each scenario task drives its own
// stimulus and compares outputs against hand-computed board values.

module tb_piece_mover;

    logic        clka;
    logic        restart;
    logic [2:0]  state;
    logic [31:0] board_in;
    logic [1:0]  curr_piece;
    logic        btn_left;
    logic        btn_right;
    logic        drop_tick;
    logic [31:0] board_out;
    logic        landed;
    logic [2:0]  piece_row;
    logic [1:0]  piece_col;

    int checks   = 0;
    int failures = 0;

    piece_mover dut (
        .clka       (clka),
        .restart    (restart),
        .state      (state),
        .board_in   (board_in),
        .curr_piece (curr_piece),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .drop_tick  (drop_tick),
        .board_out  (board_out),
        .landed     (landed),
        .piece_row  (piece_row),
        .piece_col  (piece_col)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic go_idle();
        state     = 3'd0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        drop_tick = 1'b0;
        step();
        step();
    endtask

    task automatic spawn(input logic [1:0] pc, input logic [31:0] b);
        curr_piece = pc;
        board_in   = b;
        state      = 3'd1;
        step();
    endtask

    task automatic tick();
        drop_tick = 1'b1;
        step();
        drop_tick = 1'b0;
    endtask

    task automatic test_reset();
        restart    = 1'b1;
        state      = 3'd1;
        board_in   = 32'hFFFF_FFFF;
        curr_piece = 2'b10;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        drop_tick  = 1'b0;
        step();
        step();
        checks++;
        if (board_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_board got=%h exp=%h", board_out, 32'h0);
        end
        checks++;
        if (landed !== 1'b0 || piece_row !== 3'd0 || piece_col !== 2'd0) begin
            failures++;
            $display("FAIL reset_outs got landed=%b row=%0d col=%0d exp 0/0/0",
                     landed, piece_row, piece_col);
        end
        restart = 1'b0;
        go_idle();
    endtask

    task automatic test_gravity();
        logic early_land;
        early_land = 1'b0;
        spawn(2'b00, 32'h0000_0002);
        checks++;
        if (board_out !== 32'h0000_0002 || piece_row !== 3'd0 || piece_col !== 2'd1) begin
            failures++;
            $display("FAIL grav_spawn got=%h row=%0d col=%0d exp=00000002 row=0 col=1",
                     board_out, piece_row, piece_col);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            if (landed !== 1'b0) early_land = 1'b1;
        end
        checks++;
        if (early_land) begin
            failures++;
            $display("FAIL grav_early_land got=1 exp=0");
        end
        checks++;
        if (board_out !== 32'h2000_0000 || piece_row !== 3'd7) begin
            failures++;
            $display("FAIL grav_bottom got=%h row=%0d exp=20000000 row=7", board_out, piece_row);
        end
        tick();
        checks++;
        if (landed !== 1'b1 || board_out !== 32'h2000_0000) begin
            failures++;
            $display("FAIL grav_land got landed=%b board=%h exp landed=1 board=20000000",
                     landed, board_out);
        end
        step();
        checks++;
        if (landed !== 1'b0 || board_out !== 32'h2000_0000) begin
            failures++;
            $display("FAIL grav_land_pulse got landed=%b board=%h exp landed=0 board=20000000",
                     landed, board_out);
        end
        go_idle();
    endtask

    task automatic test_lateral();
        spawn(2'b01, 32'h0000_0006);
        btn_left = 1'b1;
        step();
        checks++;
        if (board_out !== 32'h0000_0003 || piece_col !== 2'd0) begin
            failures++;
            $display("FAIL lat_left got=%h col=%0d exp=00000003 col=0", board_out, piece_col);
        end
        step();
        checks++;
        if (board_out !== 32'h0000_0003 || piece_col !== 2'd0) begin
            failures++;
            $display("FAIL lat_left_wall got=%h col=%0d exp=00000003 col=0", board_out, piece_col);
        end
        btn_left  = 1'b0;
        btn_right = 1'b1;
        step();
        step();
        checks++;
        if (board_out !== 32'h0000_000C || piece_col !== 2'd2) begin
            failures++;
            $display("FAIL lat_right got=%h col=%0d exp=0000000c col=2", board_out, piece_col);
        end
        step();
        checks++;
        if (board_out !== 32'h0000_000C || piece_col !== 2'd2) begin
            failures++;
            $display("FAIL lat_right_wall got=%h col=%0d exp=0000000c col=2", board_out, piece_col);
        end
        btn_right = 1'b0;
        go_idle();
    endtask

    task automatic test_collision_landing();
        spawn(2'b10, 32'h6000_0066);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (board_out !== 32'h6660_0000 || piece_row !== 3'd5 || landed !== 1'b0) begin
            failures++;
            $display("FAIL coll_fall got=%h row=%0d landed=%b exp=66600000 row=5 landed=0",
                     board_out, piece_row, landed);
        end
        tick();
        checks++;
        if (landed !== 1'b1 || board_out !== 32'h6660_0000 || piece_row !== 3'd5) begin
            failures++;
            $display("FAIL coll_land got landed=%b board=%h row=%0d exp landed=1 board=66600000 row=5",
                     landed, board_out, piece_row);
        end
        // A further tick in DONE must not produce another pulse.
        tick();
        checks++;
        if (landed !== 1'b0 || board_out !== 32'h6660_0000) begin
            failures++;
            $display("FAIL coll_done got landed=%b board=%h exp landed=0 board=66600000",
                     landed, board_out);
        end
        go_idle();
    endtask

    task automatic test_side_collision();
        spawn(2'b00, 32'h0000_0003);
        btn_left = 1'b1;
        step();
        checks++;
        if (board_out !== 32'h0000_0003 || piece_col !== 2'd1) begin
            failures++;
            $display("FAIL side_block got=%h col=%0d exp=00000003 col=1", board_out, piece_col);
        end
        btn_right = 1'b1;
        step();
        checks++;
        if (board_out !== 32'h0000_0003 || piece_col !== 2'd1) begin
            failures++;
            $display("FAIL side_both got=%h col=%0d exp=00000003 col=1", board_out, piece_col);
        end
        btn_left = 1'b0;
        step();
        checks++;
        if (board_out !== 32'h0000_0005 || piece_col !== 2'd2) begin
            failures++;
            $display("FAIL side_right got=%h col=%0d exp=00000005 col=2", board_out, piece_col);
        end
        btn_right = 1'b0;
        go_idle();
    endtask

    task automatic test_priority();
        spawn(2'b00, 32'h0000_0002);
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        checks++;
        if (board_out !== 32'h0000_0020 || piece_row !== 3'd1 || piece_col !== 2'd1) begin
            failures++;
            $display("FAIL prio_drop got=%h row=%0d col=%0d exp=00000020 row=1 col=1",
                     board_out, piece_row, piece_col);
        end
        go_idle();
    endtask

    task automatic test_l_shape();
        // L at (0,1) = cells (0,1),(1,1),(1,2) -> 0x62; move left then drop.
        spawn(2'b11, 32'h0000_0062);
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        tick();
        checks++;
        if (board_out !== 32'h0000_0310 || piece_row !== 3'd1 || piece_col !== 2'd0) begin
            failures++;
            $display("FAIL l_move got=%h row=%0d col=%0d exp=00000310 row=1 col=0",
                     board_out, piece_row, piece_col);
        end
        go_idle();
    endtask

    task automatic test_reset_abort();
        // Synchronous restart in the middle of ACTIVE.
        spawn(2'b00, 32'h0000_0002);
        tick();
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if (board_out !== 32'h0 || landed !== 1'b0 || piece_row !== 3'd0 || piece_col !== 2'd0) begin
            failures++;
            $display("FAIL abort_restart got=%h landed=%b row=%0d col=%0d exp=0 0 0 0",
                     board_out, landed, piece_row, piece_col);
        end
        // Still in MOVE and back in IDLE: the next cycle re-latches board_in.
        board_in = 32'h0000_1002;
        step();
        checks++;
        if (board_out !== 32'h0000_1002 || piece_row !== 3'd0 || piece_col !== 2'd1) begin
            failures++;
            $display("FAIL abort_relatch1 got=%h row=%0d col=%0d exp=00001002 row=0 col=1",
                     board_out, piece_row, piece_col);
        end
        // Phase change mid-ACTIVE: no landed pulse, board held.
        tick();
        state = 3'd2;
        drop_tick = 1'b1;
        step();
        drop_tick = 1'b0;
        step();
        checks++;
        if (landed !== 1'b0 || board_out !== 32'h0000_1020 || piece_row !== 3'd1) begin
            failures++;
            $display("FAIL abort_phase got landed=%b board=%h row=%0d exp landed=0 board=00001020 row=1",
                     landed, board_out, piece_row);
        end
        spawn(2'b01, 32'h0000_0006);
        checks++;
        if (board_out !== 32'h0000_0006 || piece_row !== 3'd0 || piece_col !== 2'd1) begin
            failures++;
            $display("FAIL abort_respawn got=%h row=%0d col=%0d exp=00000006 row=0 col=1",
                     board_out, piece_row, piece_col);
        end
        tick();
        checks++;
        if (board_out !== 32'h0000_0060 || piece_row !== 3'd1) begin
            failures++;
            $display("FAIL abort_respawn_drop got=%h row=%0d exp=00000060 row=1",
                     board_out, piece_row);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_lateral();
        test_collision_landing();
        test_side_collision();
        test_priority();
        test_l_shape();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
